// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: pixel buffer in front of the 2-bit VGA output stage.
// A producer writes 6-bit {R,G,B} pixels over valid/ready. The VGA stage
// pops one pixel per clock while pix_req is high. The popped pixel is
// registered onto pix_out one clock later. frame_start flushes the buffer
// so each frame starts aligned. Sticky underflow/overflow flags record
// starvation and dropped writes until clr_status clears them.
//
// Optional build macro VGA_PIXEL_FIFO_HOLD_EN: when defined, an underflow
// repeats the last pixel on pix_out. When undefined (default), an
// underflow drives black. pix_valid is 0 on underflow in both builds.
module vga_pixel_fifo #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic [ADDR_W:0]   level,
  output logic              underflow,
  output logic              overflow,
  input  logic              clr_status
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  // Storage and pointers. The top pointer bit is the wrap bit. Only the
  // low ADDR_W bits address the RAM.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic underflow_evt;
  logic overflow_evt;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

  // A flush cycle refuses writes, so the producer never sees a write
  // accepted and then silently lost.
  assign wr_ready = !full && !frame_start;

  // Transfer qualifiers. frame_start cancels both the read and the write.
  // The write side is already cancelled through wr_ready.
  assign wr_en = wr_valid && wr_ready;
  assign rd_en = pix_req && !empty && !frame_start;

  // Status events count whatever the flush does. The flags record what the
  // interface saw, not what the buffer did with it.
  assign underflow_evt = pix_req && empty;
  assign overflow_evt  = wr_valid && full;

  // RAM write port.
  // NOTE: the RAM array has no reset. Its contents are never observed
  // before being written, and leaving it unreset lets it map onto
  // distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Pointer and occupancy update. A flush takes priority over transfers.
  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Registered output toward the VGA stage. Blanking and flush cycles
  // force black. Underflow drives black or holds, depending on the build.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else if (frame_start || !pix_req) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else if (!empty) begin
      pix_out   <= mem[rd_ptr[ADDR_W-1:0]];
      pix_valid <= 1'b1;
    end else begin
`ifdef VGA_PIXEL_FIFO_HOLD_EN
      pix_out   <= pix_out;
`else
      pix_out   <= '0;
`endif
      pix_valid <= 1'b0;
    end
  end

  // Sticky status flags. A new event in the same cycle as clr_status wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= (underflow && !clr_status) || underflow_evt;
      overflow  <= (overflow  && !clr_status) || overflow_evt;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo. Expected values are hand-computed
// from the pixel patterns written. Concurrent traffic is checked against a
// queue model.
module tb_vga_pixel_fifo;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              frame_start;
  logic              pix_req;
  logic [DATA_W-1:0] pix_out;
  logic              pix_valid;
  logic [ADDR_W:0]   level;
  logic              underflow;
  logic              overflow;
  logic              clr_status;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_pix;

  vga_pixel_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .level       (level),
    .underflow   (underflow),
    .overflow    (overflow),
    .clr_status  (clr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock. Sampling and driving both happen 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    clr_status  = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_pix_out",   pix_out,   0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_level",     level,     0);
    check("rst_underflow", underflow, 0);
    check("rst_overflow",  overflow,  0);
    reset_n = 1'b1;
    #1;
    check("rst_wr_ready", wr_ready, 1);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      write_one(DATA_W'(i));
      check("fill_level", level, i);
    end
    check("full_wr_ready", wr_ready, 0);

    // Overflow: 0x3F is refused
    write_one(6'h3F);
    check("ovf_flag",  overflow, 1);
    check("ovf_level", level,    16);

    // Read and write while full: only the read happens
    wr_valid = 1'b1;
    wr_data  = 6'h3F;
    pix_req  = 1'b1;
    #1;
    check("full_rw_wr_ready", wr_ready, 0);
    tick();
    wr_valid = 1'b0;
    check("full_rw_pix",   pix_out,   6'h01);
    check("full_rw_valid", pix_valid, 1);
    check("full_rw_level", level,     15);

    // Clear overflow with no new event
    pix_req    = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("ovf_clear", overflow, 0);
    check("blank_pix", pix_out,  0);

    // Drain the remaining 15 pixels. Each one appears the cycle after its request.
    for (int i = 2; i <= 16; i++) begin
      pix_req = 1'b1;
      tick();
      check("drain_pix",   pix_out,   i);
      check("drain_valid", pix_valid, 1);
    end
    pix_req = 1'b0;
    tick();
    check("drain_level", level,     0);
    check("drain_blank", pix_valid, 0);
    check("drain_uf",    underflow, 0);

    // Underflow after last pixel 0x2A
    write_one(6'h2A);
    pix_req = 1'b1;
    tick();
    check("uf_last_pix", pix_out, 6'h2A);
    tick();
`ifdef VGA_PIXEL_FIFO_HOLD_EN
    check("uf_pix", pix_out, 6'h2A);
`else
    check("uf_pix", pix_out, 6'h00);
`endif
    check("uf_valid", pix_valid, 0);
    check("uf_flag",  underflow, 1);

    // Read and write while empty: the write lands, the read underflows
    pix_req    = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 6'h07;
    clr_status = 1'b1;
    tick();
    wr_valid   = 1'b0;
    clr_status = 1'b0;
    check("empty_rw_level", level,     1);
    check("empty_rw_valid", pix_valid, 0);
    check("empty_rw_uf",    underflow, 1);
    tick();
    check("empty_rw_pix", pix_out, 6'h07);
    pix_req    = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("uf_clear", underflow, 0);

    // Concurrent read/write at level 5 over 20 cycles, across pointer wrap
    for (int i = 0; i < 5; i++) begin
      write_one(DATA_W'(8'h20 + i));
      model_q.push_back(DATA_W'(8'h20 + i));
    end
    check("conc_start_level", level, 5);
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_W'(8'h25 + i);
      pix_req  = 1'b1;
      model_q.push_back(wr_data);
      exp_pix = model_q.pop_front();
      tick();
      check("conc_pix",   pix_out,   exp_pix);
      check("conc_valid", pix_valid, 1);
      check("conc_level", level,     5);
    end
    wr_valid = 1'b0;
    pix_req  = 1'b0;

    // Frame flush at level 9 with a colliding write and read
    for (int i = 0; i < 4; i++) write_one(DATA_W'(8'h39 + i));
    check("flush_pre_level", level, 9);
    frame_start = 1'b1;
    wr_valid    = 1'b1;
    wr_data     = 6'h15;
    pix_req     = 1'b1;
    #1;
    check("flush_wr_ready", wr_ready, 0);
    tick();
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    check("flush_level", level,     0);
    check("flush_valid", pix_valid, 0);
    check("flush_pix",   pix_out,   0);
    tick();
    check("flush_no_data_valid", pix_valid, 0);
    check("flush_no_data_pix",   pix_out,   0);
    pix_req = 1'b0;
    write_one(6'h11);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    check("post_flush_pix", pix_out, 6'h11);

    // Asynchronous reset mid-transfer, away from any clock edge
    write_one(6'h0A);
    write_one(6'h0B);
    pix_req = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", level,     0);
    check("async_rst_valid", pix_valid, 0);
    check("async_rst_pix",   pix_out,   0);
    pix_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fifo.md
Name: vga_pixel_fifo

Overview:
- Pixel buffer that sits directly upstream of the 2-bit VGA output stage.
- Accepts 6-bit RGB pixels (R[1:0],G[1:0],B[1:0]) from the Qsys-side producer over a valid/ready handshake.
- Pops one pixel per clock while the VGA stage requests active video; presents it on pix_out with 1-cycle latency.
- Provides frame re-alignment (flush on frame start) and sticky underflow/overflow status.

Parameters:
- DATA_W, 6, pixel width: {R[1:0],G[1:0],B[1:0]}, R in the MSBs.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W entries (16 by default).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  producer has a pixel on wr_data.
- wr_data  in  DATA_W  pixel to write.
- wr_ready  out  1  FIFO can accept; a write occurs when wr_valid && wr_ready.
- frame_start  in  1  one-cycle pulse at start of frame (from Vs edge); flushes the FIFO.
- pix_req  in  1  VGA stage is in active video (not Blank); pop request.
- pix_out  out  DATA_W  registered pixel to VGA stage.
- pix_valid  out  1  pix_out holds real FIFO data this cycle.
- level  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- underflow  out  1  sticky: pix_req seen while empty.
- overflow  out  1  sticky: wr_valid seen while full.
- clr_status  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async, reset_n=0): wr_ptr=rd_ptr=0, level=0, pix_out=0, pix_valid=0, underflow=0, overflow=0. wr_ready is combinational: 1 once out of reset, since the FIFO is empty.
- Storage: circular RAM of 2**ADDR_W words; pointers are ADDR_W+1 bits with a wrap bit. full = (level==2**ADDR_W); empty = (level==0).
- wr_ready = !full && !frame_start.
- Write: on wr_valid && wr_ready, mem[wr_ptr]<=wr_data and wr_ptr increments, wrapping 15->0 at the default depth.
- Read: on pix_req && !empty, pix_out<=mem[rd_ptr], pix_valid<=1 and rd_ptr increments. Latency is one clock from the pix_req cycle to pix_out.
- pix_req && empty: pix_valid<=0 and underflow<=1. pix_out behaviour is set by the optional feature.
- !pix_req: pix_out<=0, pix_valid<=0. Output is forced black during blanking.
- Simultaneous read and write while not full and not empty: both occur and level is unchanged.
- Simultaneous read and write while full: the read occurs, the write is refused (wr_ready=0 that cycle), level decrements by 1.
- Simultaneous read and write while empty: the write occurs, the read underflows, level becomes 1. There is no fall-through.
- overflow<=1 on any cycle with wr_valid && full.
- frame_start has highest priority:
  - Both pointers reset to 0, level=0.
  - A write in the same cycle is discarded.
  - A read in the same cycle is discarded: pix_valid<=0, pix_out<=0.
  - Sticky flags are unaffected.
- clr_status clears both sticky flags. If a new underflow or overflow event occurs in the same cycle, the set wins.
- level is registered and reflects all updates from the previous edge.
- Reset asserted mid-transfer discards all contents immediately, independent of clk.

Optional Feature:
- Macro: VGA_PIXEL_FIFO_HOLD_EN.
- Defined: on underflow, pix_out holds its previous value (last pixel repeats) and pix_valid=0.
- Not defined: on underflow, pix_out<=0 (black) and pix_valid=0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check: reset_n low for 2 cycles -> pix_out=0, pix_valid=0, level=0, wr_ready=1, underflow=0, overflow=0.
- Fill/drain: write 0x01..0x10 (16 pixels) -> level=16, wr_ready=0; then pix_req high for 16 cycles -> pix_out=0x01..0x10, each appearing 1 cycle after its request, then level=0.
- Overflow: full FIFO, wr_valid=1 with 0x3F -> overflow=1, level stays 16, 0x3F is never read out; clr_status pulse -> overflow=0.
- Underflow: FIFO empty, pix_req=1 after last pixel 0x2A -> underflow=1, pix_valid=0; pix_out=0x00, or 0x2A with VGA_PIXEL_FIFO_HOLD_EN.
- Concurrent read/write: level=5, wr_valid and pix_req high for 20 cycles -> level stays 5, output order equals write order, pointers wrap cleanly.
- Frame flush: level=9, frame_start pulse together with wr_valid=1 (0x15) and pix_req=1 -> next cycle level=0, pix_valid=0, 0x15 is never read out.
